// File: rtl/dma_chan_arbiter.sv
// dma_chan_arbiter
//   Round-robin arbiter/sequencer sharing one DMA engine among NCH channels.
//   A request is granted (one-hot gnt), the engine gets a one-cycle start,
//   the arbiter then waits for eng_done or aborts on a watchdog timeout, and
//   finally releases the grant and advances the round-robin pointer.
//
// Handshake: req[i] is a level held by the channel until it sees gnt[i];
//   gnt stays high from grant until the transfer ends, and dropping req
//   while granted has no effect. eng_start and eng_abort are single-cycle
//   pulses; eng_done is a single-cycle pulse honoured only in BUSY.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   req        per-channel request levels
//   gnt        one-hot grant
//   eng_start  one-cycle start pulse to the engine
//   eng_chan   index of the granted channel (valid while gnt != 0)
//   eng_done   engine completion pulse
//   eng_abort  one-cycle abort pulse on watchdog timeout
//   err        sticky per-channel timeout flags
//   err_clr    per-bit clear of err (a same-cycle set wins)
//   busy       high whenever the arbiter is not idle
//
// Optional feature: DMA_ARB_KEYLOCK_EN adds input key_in and parameter KEY.
//   With key_in != KEY the idle state diverts to IDLE_D, which grants with
//   fixed priority (lowest index first) and leaves the pointer untouched.
//
// State encoding: IDLE=0, GRANT=1, BUSY=2, RELEASE=3, IDLE_D=4.
// All outputs are registered.
module dma_chan_arbiter #(
    parameter int NCH     = 4,
    parameter int CHW     = 2,
    parameter int TOW     = 8,
    parameter int TIMEOUT = 200
`ifdef DMA_ARB_KEYLOCK_EN
    ,
    parameter logic [7:0] KEY = 8'hA5
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt,
    output logic           eng_start,
    output logic [CHW-1:0] eng_chan,
    input  logic           eng_done,
    output logic           eng_abort,
    output logic [NCH-1:0] err,
    input  logic [NCH-1:0] err_clr,
    output logic           busy
`ifdef DMA_ARB_KEYLOCK_EN
    ,
    input  logic [7:0]     key_in
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_BUSY    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
`ifdef DMA_ARB_KEYLOCK_EN
    localparam logic [2:0] S_IDLE_D  = 3'd4;
`endif

    logic [2:0]     state, state_next;
    logic [CHW-1:0] ptr, ptr_next;
    logic [TOW-1:0] wd, wd_next;
    logic           fixed_pri, fixed_pri_next;
    logic [NCH-1:0] gnt_next, err_next;
    logic [CHW-1:0] chan_next;
    logic           start_next, abort_next, busy_next;
    logic [CHW-1:0] rr_pick;
    logic           rr_found;
    logic           timeout_hit;
    logic           idle_grant;

    assign timeout_hit = (wd == TOW'(TIMEOUT - 1));

`ifdef DMA_ARB_KEYLOCK_EN
    logic           key_ok;
    logic [CHW-1:0] fx_pick;
    assign key_ok     = (key_in == KEY);
    assign idle_grant = key_ok && (|req);

    // Fixed priority: scanning downwards leaves the lowest set index.
    always_comb begin
        fx_pick = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) fx_pick = CHW'(i);
        end
    end
`else
    assign idle_grant = |req;
`endif

    // Round-robin: first set request scanning ptr, ptr+1, ... modulo NCH.
    always_comb begin
        rr_pick  = '0;
        rr_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!rr_found && req[CHW'((int'(ptr) + i) % NCH)]) begin
                rr_found = 1'b1;
                rr_pick  = CHW'((int'(ptr) + i) % NCH);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE: begin
`ifdef DMA_ARB_KEYLOCK_EN
                if (!key_ok)         state_next = S_IDLE_D;
                else
`endif
                if (idle_grant)      state_next = S_GRANT;
                else                 state_next = S_IDLE;
            end
`ifdef DMA_ARB_KEYLOCK_EN
            S_IDLE_D: begin
                if (|req)            state_next = S_GRANT;
                else if (key_ok)     state_next = S_IDLE;
                else                 state_next = S_IDLE_D;
            end
`endif
            S_GRANT:                 state_next = S_BUSY;
            // Done takes priority over a coincident timeout.
            S_BUSY: begin
                if (eng_done || timeout_hit) state_next = S_RELEASE;
                else                         state_next = S_BUSY;
            end
            S_RELEASE:               state_next = S_IDLE;
            default:                 state_next = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and datapath.
    // gnt drops on the BUSY exit edge so eng_done -> gnt low is one cycle.
    always_comb begin
        gnt_next       = gnt;
        chan_next      = eng_chan;
        start_next     = 1'b0;
        abort_next     = 1'b0;
        err_next       = err & ~err_clr;
        ptr_next       = ptr;
        wd_next        = wd;
        fixed_pri_next = fixed_pri;
        case (state)
            S_IDLE: begin
                if (idle_grant) begin
                    gnt_next       = {{(NCH-1){1'b0}}, 1'b1} << rr_pick;
                    chan_next      = rr_pick;
                    fixed_pri_next = 1'b0;
                end
            end
`ifdef DMA_ARB_KEYLOCK_EN
            S_IDLE_D: begin
                if (|req) begin
                    gnt_next       = {{(NCH-1){1'b0}}, 1'b1} << fx_pick;
                    chan_next      = fx_pick;
                    fixed_pri_next = 1'b1;
                end
            end
`endif
            S_GRANT: begin
                start_next = 1'b1;
                wd_next    = '0;
            end
            S_BUSY: begin
                wd_next = (wd == TOW'(TIMEOUT)) ? wd : wd + 1'b1;
                if (eng_done) begin
                    gnt_next = '0;
                end else if (timeout_hit) begin
                    gnt_next           = '0;
                    abort_next         = 1'b1;
                    err_next[eng_chan] = 1'b1;
                end
            end
            S_RELEASE: begin
                gnt_next = '0;
                // Fixed-priority grants never move the pointer.
                if (!fixed_pri)
                    ptr_next = (eng_chan == CHW'(NCH - 1)) ? '0 : eng_chan + 1'b1;
            end
            default: begin
                gnt_next = '0;
            end
        endcase
`ifdef DMA_ARB_KEYLOCK_EN
        busy_next = (state_next != S_IDLE) && (state_next != S_IDLE_D);
`else
        busy_next = (state_next != S_IDLE);
`endif
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            eng_chan  <= '0;
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            err       <= '0;
            busy      <= 1'b0;
            ptr       <= '0;
            wd        <= '0;
            fixed_pri <= 1'b0;
        end else begin
            gnt       <= gnt_next;
            eng_chan  <= chan_next;
            eng_start <= start_next;
            eng_abort <= abort_next;
            err       <= err_next;
            busy      <= busy_next;
            ptr       <= ptr_next;
            wd        <= wd_next;
            fixed_pri <= fixed_pri_next;
        end
    end

endmodule
